pulse_burst_generator: RTL and testbench

Parametrised successor to the single-shot laser pulse generator. One start edge produces a programmable burst of N probe pulses, each with programmable width and repetition period, after an optional start delay. Per-pulse sync strobes frame the ADC capture, and a done strobe marks the end of the burst. The block sits in the ADC clock domain between the acquisition controller (start, configuration) and the optical modulator driver (pulse_o).

---
 rtl/pulse_burst_generator.sv | 136 +++++++++++++
 tb/tb_pulse_burst_generator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_burst_generator.sv
// Burst pulse generator: one start edge yields count_i pulses of programmable
// width and period after an optional delay, with per-pulse sync and done strobes.
module pulse_burst_generator #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned NUM_W = 16,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk_adc_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] delay_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [NUM_W-1:0] count_i,
    output logic             pulse_o,
    output logic             sync_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

    typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_q, period_q, low_len;
    logic [NUM_W-1:0] rem_q, rem_d;
    logic             start_prev_q, start_edge, phase_end;
    logic             cfg_load, done_d;
    logic             pulse_q, sync_q, busy_q, done_q;

    // Decrement only while above STEP, so the counter never wraps.
    assign phase_end  = (cnt_q <= STEP_C);
    assign start_edge = start_i & ~start_prev_q;
    assign low_len    = (period_q > width_q) ? (period_q - width_q) : STEP_C;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        cfg_load = 1'b0;
        done_d   = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_edge && (count_i != '0)) begin
                        cfg_load = 1'b1;
                        rem_d    = count_i;
                        if (delay_i != '0) begin
                            state_d = DELAY;
                            cnt_d   = delay_i;
                        end else begin
                            state_d = HIGH;
                            cnt_d   = width_i;
                        end
                    end
                end
                DELAY: begin
                    if (phase_end) begin
                        state_d = HIGH;
                        cnt_d   = width_q;
                    end else begin
                        cnt_d = cnt_q - STEP_C;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        if (rem_q > NUM_W'(1)) begin
                            rem_d   = rem_q - NUM_W'(1);
                            state_d = LOW;
                            cnt_d   = low_len;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - STEP_C;
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        state_d = HIGH;
                        cnt_d   = width_q;
                    end else begin
                        cnt_d = cnt_q - STEP_C;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_adc_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            width_q      <= '0;
            period_q     <= '0;
            start_prev_q <= 1'b1;
            pulse_q      <= 1'b0;
            sync_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            start_prev_q <= start_i;
            if (cfg_load) begin
                width_q  <= width_i;
                period_q <= period_i;
            end
            // Outputs decoded from the next state so they align with it.
            pulse_q <= (state_d == HIGH);
            sync_q  <= (state_d == HIGH) && (state_q != HIGH);
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
        end
    end

    assign pulse_o = pulse_q;
    assign sync_o  = sync_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_pulse_burst_generator.sv
// Self-checking bench: three instances (STEP 1, 4, 2^30) on shared stimulus,
// each checked every cycle against an arithmetic burst-timing model.
module tb_pulse_burst_generator;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [31:0] delay, width, period;
    logic [15:0] count;
    logic [2:0]  pulse_w, sync_w, busy_w, done_w;

    always #5 clk = ~clk;

    pulse_burst_generator #(.CNT_W(32), .NUM_W(16), .STEP(1)) u_s1 (
        .clk_adc_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .delay_i(delay), .width_i(width), .period_i(period), .count_i(count),
        .pulse_o(pulse_w[0]), .sync_o(sync_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]));

    pulse_burst_generator #(.CNT_W(32), .NUM_W(16), .STEP(4)) u_s4 (
        .clk_adc_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .delay_i(delay), .width_i(width), .period_i(period), .count_i(count),
        .pulse_o(pulse_w[1]), .sync_o(sync_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]));

    pulse_burst_generator #(.CNT_W(32), .NUM_W(16), .STEP(32'h4000_0000)) u_big (
        .clk_adc_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .delay_i(delay), .width_i(width), .period_i(period), .count_i(count),
        .pulse_o(pulse_w[2]), .sync_o(sync_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2]));

    longint steps [3] = '{64'd1, 64'd4, 64'h4000_0000};
    bit     m_act [3];
    longint m_s [3], m_D [3], m_H [3], m_L [3], m_N [3];
    bit     m_prev;
    longint cyc;
    int     n_vec, n_err;

    typedef struct {
        int          sel;
        logic [31:0] delay, width, period;
        logic [15:0] count;
        int          first_rise, spacing, done_at;
    } vec_t;
    vec_t tbl [6];

    function automatic longint cdiv(longint a, longint b);
        return (a + b - 1) / b;
    endfunction

    task automatic cmp(input string name, input int idx, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] cycle=%0d got=%b expected=%b", name, idx, cyc, act, exp);
        end
    endtask

    task automatic cmp_int(input string name, input int idx, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d] got=%0d expected=%0d", name, idx, act, exp);
        end
    endtask

    // Burst timing: pulse k rises at s+1+D+k*(H+L); done at the cycle after the last high.
    task automatic model_edge();
        longint x, endc, lowlen;
        bit     edge_seen, idle;
        x = cyc;
        edge_seen = start && !m_prev;
        for (int i = 0; i < 3; i++) begin
            endc = m_s[i] + 1 + m_D[i] + m_N[i] * (m_H[i] + m_L[i]) - m_L[i];
            idle = !m_act[i] || (x >= endc);
            if (reset || abort) begin
                m_act[i] = 1'b0;
            end else if (idle && edge_seen && count != 0) begin
                m_act[i] = 1'b1;
                m_s[i]   = x;
                m_N[i]   = longint'(count);
                m_D[i]   = (delay == 0) ? 0 : cdiv(longint'(delay), steps[i]);
                m_H[i]   = (width == 0) ? 1 : cdiv(longint'(width), steps[i]);
                lowlen   = (period > width) ? longint'(period) - longint'(width) : steps[i];
                m_L[i]   = cdiv(lowlen, steps[i]);
                if (m_L[i] < 1) m_L[i] = 1;
            end
        end
        m_prev = reset ? 1'b1 : start;
        cyc++;
    endtask

    task automatic check_all();
        longint rel, tot, per;
        logic   ep, es, eb, ed;
        for (int i = 0; i < 3; i++) begin
            ep = 0; es = 0; eb = 0; ed = 0;
            if (m_act[i]) begin
                per = m_H[i] + m_L[i];
                tot = m_N[i] * per - m_L[i];
                rel = cyc - m_s[i] - 1 - m_D[i];
                eb  = (rel < tot);
                ep  = (rel >= 0) && (rel < tot) && ((rel % per) < m_H[i]);
                es  = (rel >= 0) && (rel < tot) && ((rel % per) == 0);
                ed  = (rel == tot);
            end
            cmp("pulse", i, pulse_w[i], ep);
            cmp("sync",  i, sync_w[i],  es);
            cmp("busy",  i, busy_w[i],  eb);
            cmp("done",  i, done_w[i],  ed);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1; abort = 0; start = 0;
        tick(); tick();
        reset = 0;
        tick();
    endtask

    task automatic set_cfg(input logic [31:0] d, input logic [31:0] w,
                           input logic [31:0] p, input logic [15:0] c);
        delay = d; width = w; period = p; count = c;
    endtask

    initial begin
        int first, second, dn;
        logic pp;
        n_vec = 0; n_err = 0; cyc = 0; m_prev = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 0; m_s[i] = 0; m_D[i] = 0; m_H[i] = 1; m_L[i] = 1; m_N[i] = 0;
        end
        reset = 1; start = 0; abort = 0;
        set_cfg(0, 0, 0, 0);

        tbl[0] = '{0, 32'd0, 32'd3, 32'd10, 16'd4, 1, 10, 34};
        tbl[1] = '{0, 32'd5, 32'd2, 32'd4, 16'd2, 6, 4, 12};
        tbl[2] = '{1, 32'd0, 32'd9, 32'd10, 16'd2, 1, 4, 8};
        tbl[3] = '{0, 32'd0, 32'd0, 32'd0, 16'd3, 1, 2, 6};
        tbl[4] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd2, 5, 5, 14};
        tbl[5] = '{0, 32'd0, 32'd0, 32'd5, 16'd1, 1, 0, 2};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_cfg(tbl[i].delay, tbl[i].width, tbl[i].period, tbl[i].count);
            start = 1;
            tick();
            first = -1; second = -1; dn = -1; pp = 1'b0;
            for (int n = 1; n <= 200; n++) begin
                if (pulse_w[tbl[i].sel] && !pp) begin
                    if (first < 0) first = n;
                    else if (second < 0) second = n;
                end
                pp = pulse_w[tbl[i].sel];
                if (done_w[tbl[i].sel]) begin
                    dn = n;
                    break;
                end
                if (n == 1) start = 0;
                if (n == 2) set_cfg(32'd1, 32'd7, 32'd3, 16'd9);
                tick();
            end
            cmp_int("first_rise", i, first, tbl[i].first_rise);
            cmp_int("spacing", i, (second < 0) ? 0 : second - first, tbl[i].spacing);
            cmp_int("done_at", i, dn, tbl[i].done_at);
            do_reset();
        end

        // Retrigger attempts during a burst must not disturb it.
        set_cfg(0, 3, 10, 4);
        start = 1; tick();
        for (int n = 0; n < 20; n++) begin
            start = ~start;
            tick();
        end
        start = 0;
        repeat (25) tick();

        // count = 0 start is ignored.
        set_cfg(0, 2, 4, 0);
        start = 1; tick();
        for (int n = 0; n < 5; n++) begin
            cmp("cnt0_busy", 0, busy_w[0], 1'b0);
            cmp("cnt0_done", 0, done_w[0], 1'b0);
            tick();
        end
        start = 0; tick();

        // start held high across reset release does not trigger.
        set_cfg(0, 2, 4, 2);
        reset = 1; start = 1;
        tick(); tick();
        reset = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            cmp("rst_hold_busy", 0, busy_w[0], 1'b0);
        end
        start = 0; tick();
        start = 1; tick();
        cmp("rst_retoggle_busy", 0, busy_w[0], 1'b1);
        start = 0;
        repeat (20) tick();

        // Abort in the second cycle of the second pulse.
        do_reset();
        set_cfg(0, 3, 10, 5);
        start = 1; tick();
        start = 0;
        repeat (11) tick();
        cmp("abort_pre_pulse", 0, pulse_w[0], 1'b1);
        abort = 1; tick();
        abort = 0;
        cmp("abort_pulse", 0, pulse_w[0], 1'b0);
        cmp("abort_busy", 0, busy_w[0], 1'b0);
        repeat (60) tick();
        start = 1; tick();
        start = 0;
        repeat (60) tick();

        // Randomised traffic against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            abort = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 5) == 0) start = ~start;
            if ($urandom_range(0, 3) == 0)
                set_cfg(($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 12)),
                        32'($urandom_range(0, 8)), 32'($urandom_range(0, 14)),
                        16'($urandom_range(0, 4)));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
